fetch_unit: RTL

//  Instruction-fetch stage directly upstream of the MIPS datapath/decoder. Owns the fetch PC,

---
 rtl/fetch_unit_pkg.sv | 26 ++
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit_fifo.sv | 67 ++++++
 rtl/fetch_unit.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, reset
// address, word increment, FIFO entry layout and an address-alignment helper.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DROP = 2'd2
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_3000;
   localparam logic [31:0] WORD_INC           = 32'h0000_0004;
   localparam int          FIFO_DEPTH_DEFAULT = 2;

   // One buffered instruction together with the address it was fetched from.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // Instruction addresses are always word aligned; low two bits are dropped.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle around the fetch stage: instruction-memory handshake, redirect
// input and the valid/ready instruction stream towards the decoder.
interface fetch_unit_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;

   // Fetch-unit side.
   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc,
      input  imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
   );

   // Environment side: memory, branch resolution and decoder.
   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc,
      output imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
   );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs. Flush dominates
// push and pop; pop on empty is ignored; the head reads as zero when empty.
module fetch_unit_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int            AW      = $clog2(DEPTH);
   localparam int            CW      = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             push_s;
   logic             pop_s;

   assign empty_o = (count_q == {CW{1'b0}});
   assign full_o  = (count_q == DEPTH_C);
   assign pop_s   = pop_i & ~empty_o;
   // A full FIFO can only take a new word when the head leaves in the same cycle.
   assign push_s  = push_i & (~full_o | pop_s);
   assign count_o = count_q;
   assign rdata_o = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

   // Storage, pointers and occupancy; flush only clears the bookkeeping.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
      end else if (flush_i) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues one outstanding word read
// at a time, buffers replies in fetch_unit_fifo and squashes in-flight work on
// a redirect.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int          FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
   input  logic          clk_i,
   input  logic          rst_i,
   fetch_unit_if.master  bus
);

   localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0] DEPTH_X = (CW + 1)'(FIFO_DEPTH);

   fetch_state_e  state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   addr_q, addr_d;
   logic          req_q, req_d;
   logic [31:0]   target_s;
   logic [31:0]   pc_next_s;
   logic          push_s;
   logic          fifo_push_s;
   logic          pop_s;
   logic          flush_s;
   logic [CW-1:0] count_s;
   logic          full_s;
   logic          empty_s;
   logic [CW:0]   cnt_pop_s;
   logic [CW:0]   cnt_pushpop_s;
   fetch_entry_t  wr_entry_s;
   fetch_entry_t  head_s;

   assign target_s      = word_align(bus.redirect_pc);
   assign pc_next_s     = fetch_pc_q + WORD_INC;
   assign pop_s         = bus.instr_ready & ~empty_s;
   // Occupancy once this cycle's pop (and optionally a push) has landed.
   assign cnt_pop_s     = {1'b0, count_s} - {{CW{1'b0}}, pop_s};
   assign cnt_pushpop_s = cnt_pop_s + {{CW{1'b0}}, 1'b1};
   assign wr_entry_s    = {addr_q, bus.imem_rdata};
   assign fifo_push_s   = push_s & (~full_s | pop_s);

   fetch_unit_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push_s),
      .pop_i   (pop_s),
      .flush_i (flush_s),
      .wdata_i (wr_entry_s),
      .rdata_o (head_s),
      .count_o (count_s),
      .full_o  (full_s),
      .empty_o (empty_s)
   );

   assign bus.imem_req    = req_q;
   assign bus.imem_addr   = addr_q;
   assign bus.instr_valid = ~empty_s;
   assign bus.instr       = head_s.instr;
   assign bus.instr_pc    = head_s.pc;

   // Next-state, PC and request decisions; a redirect overrides everything.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_d      = req_q;
      addr_d     = addr_q;
      push_s     = 1'b0;
      flush_s    = 1'b0;
      if (bus.redirect) begin
         flush_s    = 1'b1;
         fetch_pc_d = target_s;
         if ((state_q != ST_IDLE) && !bus.imem_ack) begin
            // The old read must still finish on the bus; its data is squashed.
            state_d = ST_DROP;
         end else begin
            state_d = ST_REQ;
            req_d   = 1'b1;
            addr_d  = target_s;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cnt_pop_s < DEPTH_X) begin
                  state_d = ST_REQ;
                  req_d   = 1'b1;
                  addr_d  = fetch_pc_q;
               end else begin
                  req_d   = 1'b0;
               end
            end
            ST_REQ: begin
               if (bus.imem_ack) begin
                  push_s     = 1'b1;
                  fetch_pc_d = pc_next_s;
                  if (cnt_pushpop_s < DEPTH_X) begin
                     req_d  = 1'b1;
                     addr_d = pc_next_s;
                  end else begin
                     req_d   = 1'b0;
                     state_d = ST_IDLE;
                  end
               end else begin
                  req_d = 1'b1;
               end
            end
            ST_DROP: begin
               if (bus.imem_ack) begin
                  if (cnt_pop_s < DEPTH_X) begin
                     state_d = ST_REQ;
                     req_d   = 1'b1;
                     addr_d  = fetch_pc_q;
                  end else begin
                     state_d = ST_IDLE;
                     req_d   = 1'b0;
                  end
               end else begin
                  req_d = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               req_d   = 1'b0;
            end
         endcase
      end
   end

   // State, PC and registered request outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= RESET_PC;
         req_q      <= 1'b0;
         addr_q     <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
      end
   end

endmodule
